// File: rtl/pendulum_episode_ctrl.sv
// Episode sequencer for the single-step Pendulum datapath: it holds {thdot,th}, launches
// one compute per accepted action, writes the result back, and counts/truncates steps.
module pendulum_episode_ctrl #(
  parameter int unsigned MAX_STEPS = 200,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ep_start,
  input  logic [63:0]       i_init_sta,
  output logic              o_ep_ready,
  input  logic              i_act_valid,
  input  logic [31:0]       i_act,
  output logic              o_act_ready,
  output logic              o_cmp_ena,
  output logic [63:0]       o_cmp_sta,
  output logic [31:0]       o_cmp_act,
  input  logic [63:0]       i_cmp_sta,
  input  logic [95:0]       i_cmp_obs,
  input  logic [31:0]       i_cmp_rwd,
  input  logic              i_cmp_valid,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [95:0]       o_obs,
  output logic [31:0]       o_rwd,
  output logic              o_trunc,
  output logic [STEP_W-1:0] o_step_cnt,
  output logic              o_err
);

  localparam int unsigned        WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [STEP_W-1:0]  STEP_MAX = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACT,
    S_LAUNCH,
    S_BUSY,
    S_OUT
  } state_e;

  state_e            state_q;
  logic [63:0]       sta_q;
  logic [31:0]       act_q;
  logic [95:0]       obs_q;
  logic [31:0]       rwd_q;
  logic [STEP_W-1:0] cnt_q;
  logic [STEP_W-1:0] cnt_d;
  logic [WD_W-1:0]   wdog_q;
  logic              err_q;
  logic              cmp_ena_q;
  logic              res_valid_q;
  logic              trunc_q;

  assign cnt_d = cnt_q + STEP_W'(1);

  // NOTE: every register here is written with <= so all of them see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sta_q       <= '0;
      act_q       <= '0;
      obs_q       <= '0;
      rwd_q       <= '0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      cmp_ena_q   <= 1'b0;
      res_valid_q <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_ep_start) begin
            sta_q   <= i_init_sta;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= S_WAIT_ACT;
          end
        end
        S_WAIT_ACT: begin
          // A restart beats an action offered in the same cycle.
          if (i_ep_start) begin
            sta_q <= i_init_sta;
            cnt_q <= '0;
            err_q <= 1'b0;
          end else if (i_act_valid) begin
            act_q   <= i_act;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cmp_ena_q <= 1'b1;
          wdog_q    <= '0;
          state_q   <= S_BUSY;
        end
        S_BUSY: begin
          // wdog_q == 0 marks the first BUSY cycle, where a leftover valid is ignored.
          if (i_cmp_valid && (wdog_q != '0)) begin
            sta_q       <= i_cmp_sta;
            obs_q       <= i_cmp_obs;
            rwd_q       <= i_cmp_rwd;
            cnt_q       <= cnt_d;
            trunc_q     <= (cnt_d == STEP_MAX);
            cmp_ena_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (wdog_q == WD_LAST) begin
            err_q     <= 1'b1;
            cmp_ena_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_OUT: begin
          if (i_res_ready) begin
            res_valid_q <= 1'b0;
            trunc_q     <= 1'b0;
            state_q     <= trunc_q ? S_IDLE : S_WAIT_ACT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ep_ready  = (state_q == S_IDLE) || (state_q == S_WAIT_ACT);
  assign o_act_ready = (state_q == S_WAIT_ACT);
  assign o_cmp_ena   = cmp_ena_q;
  assign o_cmp_sta   = sta_q;
  assign o_cmp_act   = act_q;
  assign o_res_valid = res_valid_q;
  assign o_obs       = obs_q;
  assign o_rwd       = rwd_q;
  assign o_trunc     = trunc_q;
  assign o_step_cnt  = cnt_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_pendulum_episode_ctrl.sv
// Scoreboard bench: the driver records expected step results, a datapath model answers
// launches, and a monitor pops and compares each presented result.
module tb_pendulum_episode_ctrl;

  localparam int MAX_STEPS = 3;
  localparam int STEP_W    = 8;
  localparam int TIMEOUT   = 24;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_ep_start;
  logic [63:0]       i_init_sta;
  logic              o_ep_ready;
  logic              i_act_valid;
  logic [31:0]       i_act;
  logic              o_act_ready;
  logic              o_cmp_ena;
  logic [63:0]       o_cmp_sta;
  logic [31:0]       o_cmp_act;
  logic [63:0]       i_cmp_sta;
  logic [95:0]       i_cmp_obs;
  logic [31:0]       i_cmp_rwd;
  logic              i_cmp_valid;
  logic              o_res_valid;
  logic              i_res_ready;
  logic [95:0]       o_obs;
  logic [31:0]       o_rwd;
  logic              o_trunc;
  logic [STEP_W-1:0] o_step_cnt;
  logic              o_err;

  pendulum_episode_ctrl #(
    .MAX_STEPS(MAX_STEPS),
    .STEP_W   (STEP_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ep_start (i_ep_start),
    .i_init_sta (i_init_sta),
    .o_ep_ready (o_ep_ready),
    .i_act_valid(i_act_valid),
    .i_act      (i_act),
    .o_act_ready(o_act_ready),
    .o_cmp_ena  (o_cmp_ena),
    .o_cmp_sta  (o_cmp_sta),
    .o_cmp_act  (o_cmp_act),
    .i_cmp_sta  (i_cmp_sta),
    .i_cmp_obs  (i_cmp_obs),
    .i_cmp_rwd  (i_cmp_rwd),
    .i_cmp_valid(i_cmp_valid),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_obs      (o_obs),
    .o_rwd      (o_rwd),
    .o_trunc    (o_trunc),
    .o_step_cnt (o_step_cnt),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] sta;
    logic [31:0] act;
    int          lat;
    bit          respond;
    bit          stale;
    logic [63:0] nsta;
    logic [95:0] obs;
    logic [31:0] rwd;
  } job_t;

  typedef struct {
    logic [63:0] nsta;
    logic [95:0] obs;
    logic [31:0] rwd;
    int          cnt;
    bit          trunc;
    int          acc;
    int          lat;
  } exp_t;

  job_t dp_q[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int hold_req = 0;

  // Reference episode model: current state, steps taken, last latched action.
  logic [63:0] ref_sta  = '0;
  int          ref_cnt  = 0;
  logic [31:0] last_act = '0;
  int          last_acc = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_for(input bit ep, input string name);
    for (int i = 0; i < 300; i++) begin
      if (ep ? o_ep_ready : o_act_ready) return;
      @(negedge i_clk);
    end
    n_checks++;
    n_err++;
    $display("FAIL %s: got no ready within 300 cycles expected ready", name);
  endtask

  task automatic do_start(input logic [63:0] init);
    wait_for(1'b1, "wait_ep_ready");
    i_init_sta = init;
    i_ep_start = 1'b1;
    @(negedge i_clk);
    i_ep_start = 1'b0;
    i_init_sta = {$urandom, $urandom};
    ref_sta    = init;
    ref_cnt    = 0;
  endtask

  task automatic do_step(input logic [31:0] act, input int lat, input bit respond,
                         input bit expect_res);
    job_t j;
    exp_t e;
    wait_for(1'b0, "wait_act_ready");
    j.sta     = ref_sta;
    j.act     = act;
    j.lat     = lat;
    j.respond = respond;
    j.stale   = ($urandom_range(0, 2) == 0);
    j.nsta    = {$urandom, $urandom};
    j.obs     = {$urandom, $urandom, $urandom};
    j.rwd     = $urandom;
    if (expect_res) begin
      ref_sta = j.nsta;
      ref_cnt++;
      e.nsta  = j.nsta;
      e.obs   = j.obs;
      e.rwd   = j.rwd;
      e.cnt   = ref_cnt;
      e.trunc = (ref_cnt == MAX_STEPS);
      e.acc   = cyc + 1;
      e.lat   = lat;
      exp_q.push_back(e);
    end
    dp_q.push_back(j);
    last_act    = act;
    last_acc    = cyc + 1;
    i_act       = act;
    i_act_valid = 1'b1;
    @(negedge i_clk);
    i_act_valid = 1'b0;
    i_act       = $urandom;
  endtask

  // Datapath model: answers each launch after its latency, optionally with a stale first-cycle valid.
  initial begin
    job_t j;
    i_cmp_valid = 1'b0;
    i_cmp_sta   = '0;
    i_cmp_obs   = '0;
    i_cmp_rwd   = '0;
    forever begin
      @(negedge i_clk);
      if (o_cmp_ena) begin
        if (dp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_launch: got o_cmp_ena=1 expected no launch (cycle %0d)", cyc);
        end else begin
          j = dp_q.pop_front();
          check("launch_sta", o_cmp_sta, j.sta);
          check("launch_act", o_cmp_act, j.act);
          if (j.stale) begin
            i_cmp_valid = 1'b1;
            i_cmp_sta   = {$urandom, $urandom};
            i_cmp_obs   = {$urandom, $urandom, $urandom};
            i_cmp_rwd   = $urandom;
            @(negedge i_clk);
            i_cmp_valid = 1'b0;
            repeat (j.lat) @(negedge i_clk);
          end else begin
            repeat (j.lat + 1) @(negedge i_clk);
          end
          if (j.respond) begin
            i_cmp_valid = 1'b1;
            i_cmp_sta   = j.nsta;
            i_cmp_obs   = j.obs;
            i_cmp_rwd   = j.rwd;
            @(negedge i_clk);
            i_cmp_valid = 1'b0;
            i_cmp_sta   = {$urandom, $urandom};
            i_cmp_obs   = {$urandom, $urandom, $urandom};
            i_cmp_rwd   = $urandom;
          end
        end
        for (int i = 0; i < 100 && o_cmp_ena; i++) @(negedge i_clk);
      end
    end
  end

  // Result consumer: random backpressure, or a forced hold of hold_req valid cycles.
  initial begin
    i_res_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (hold_req > 0) begin
        i_res_ready = 1'b0;
        if (o_res_valid) hold_req--;
      end else begin
        i_res_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pop on first presentation, then require the result to stay put until accepted.
  initial begin
    exp_t cur;
    bit   in_res;
    in_res = 1'b0;
    forever begin
      @(negedge i_clk);
      #1;
      if (o_res_valid) begin
        check("no_ena_in_out", o_cmp_ena, 1'b0);
        if (!in_res) begin
          in_res = 1'b1;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_result: got o_res_valid=1 expected none (cycle %0d)", cyc);
            cur.obs   = o_obs;
            cur.rwd   = o_rwd;
            cur.trunc = o_trunc;
            cur.cnt   = int'(o_step_cnt);
          end else begin
            cur = exp_q.pop_front();
            check("step_latency", cyc - cur.acc, 3 + cur.lat);
            check("res_obs", o_obs, cur.obs);
            check("res_rwd", o_rwd, cur.rwd);
            check("res_state", o_cmp_sta, cur.nsta);
            check("res_step_cnt", o_step_cnt, cur.cnt);
            check("res_trunc", o_trunc, cur.trunc);
          end
        end else begin
          check("hold_obs", o_obs, cur.obs);
          check("hold_rwd", o_rwd, cur.rwd);
          check("hold_trunc", o_trunc, cur.trunc);
          check("hold_step_cnt", o_step_cnt, cur.cnt);
        end
        if (i_res_ready) in_res = 1'b0;
      end else if (in_res) begin
        n_checks++;
        n_err++;
        $display("FAIL res_valid_drop: got o_res_valid=0 expected 1 until accepted (cycle %0d)", cyc);
        in_res = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0] new_init;
    bit          seen;
    i_rst       = 1'b1;
    i_ep_start  = 1'b0;
    i_init_sta  = '0;
    i_act_valid = 1'b0;
    i_act       = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    check("rst_ep_ready", o_ep_ready, 1'b1);
    check("rst_act_ready", o_act_ready, 1'b0);
    check("rst_cmp_ena", o_cmp_ena, 1'b0);
    check("rst_cmp_sta", o_cmp_sta, 64'h0);
    check("rst_cmp_act", o_cmp_act, 32'h0);
    check("rst_res_valid", o_res_valid, 1'b0);
    check("rst_obs_rwd", {o_obs, o_rwd}, 128'h0);
    check("rst_trunc_err_cnt", {o_trunc, o_err, o_step_cnt}, 10'h0);

    // Directed episode: fixed vectors, latency 20, a 10-cycle hold, then truncation.
    do_start(64'h3f3b93a1_4049999a);
    hold_req = 10;
    do_step(32'h3f3c8151, 20, 1'b1, 1'b1);
    do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
    do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
    wait_for(1'b1, "trunc_to_idle");
    check("trunc_ep_ready", o_ep_ready, 1'b1);
    check("trunc_act_ready", o_act_ready, 1'b0);
    check("trunc_step_cnt", o_step_cnt, MAX_STEPS);
    check("trunc_cleared", o_trunc, 1'b0);

    // Restart and action offered together: restart wins, nothing launches.
    do_start({$urandom, $urandom});
    do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
    wait_for(1'b0, "restart_wait_act");
    new_init    = {$urandom, $urandom};
    i_ep_start  = 1'b1;
    i_init_sta  = new_init;
    i_act_valid = 1'b1;
    i_act       = ~last_act;
    @(negedge i_clk);
    i_ep_start  = 1'b0;
    i_act_valid = 1'b0;
    ref_sta     = new_init;
    ref_cnt     = 0;
    check("restart_act_ready", o_act_ready, 1'b1);
    check("restart_no_launch", o_cmp_ena, 1'b0);
    check("restart_step_cnt", o_step_cnt, 0);
    check("restart_state", o_cmp_sta, new_init);
    check("restart_act_kept", o_cmp_act, last_act);
    repeat (3) @(negedge i_clk);
    check("restart_still_idle", o_cmp_ena, 1'b0);
    for (int s = 0; s < MAX_STEPS; s++) do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
    wait_for(1'b1, "restart_ep_end");

    // Random episodes, one of them restarted after its first step.
    for (int ep = 0; ep < 5; ep++) begin
      do_start({$urandom, $urandom});
      if (ep == 1) begin
        do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
        do_start({$urandom, $urandom});
      end
      for (int s = 0; s < MAX_STEPS; s++) do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
      wait_for(1'b1, "rand_ep_end");
      check("rand_end_cnt", o_step_cnt, MAX_STEPS);
      check("rand_end_act_ready", o_act_ready, 1'b0);
    end

    // Hung datapath: watchdog fires after TIMEOUT busy cycles and leaves the state alone.
    do_start({$urandom, $urandom});
    do_step($urandom, $urandom_range(0, 20), 1'b1, 1'b1);
    do_step($urandom, 0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (o_err) begin
        seen = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    check("wdog_fired", seen, 1'b1);
    check("wdog_cycles", cyc - last_acc, TIMEOUT + 1);
    check("wdog_idle", {o_ep_ready, o_act_ready, o_cmp_ena}, 3'b100);
    check("wdog_state_kept", o_cmp_sta, ref_sta);
    check("wdog_cnt_kept", o_step_cnt, ref_cnt);
    do_start({$urandom, $urandom});
    check("wdog_err_cleared", o_err, 1'b0);
    check("wdog_restart_cnt", o_step_cnt, 0);

    // Reset while busy; the late valid pulse that follows must be ignored.
    do_step($urandom, 15, 1'b1, 1'b0);
    repeat (4) @(negedge i_clk);
    check("busy_before_rst", o_cmp_ena, 1'b1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    ref_sta = '0;
    ref_cnt = 0;
    check("midrst_cmp_ena", o_cmp_ena, 1'b0);
    check("midrst_ready", {o_ep_ready, o_act_ready}, 2'b10);
    check("midrst_regs", {o_cmp_sta, o_cmp_act, o_rwd}, 128'h0);
    check("midrst_obs", o_obs, 96'h0);
    check("midrst_flags", {o_res_valid, o_trunc, o_err, o_step_cnt}, 11'h0);
    repeat (20) @(negedge i_clk);
    check("late_valid_ignored", {o_res_valid, o_cmp_ena, o_act_ready}, 3'b000);
    check("late_valid_cnt", o_step_cnt, 0);
    check("late_valid_sta", o_cmp_sta, 64'h0);

    do_start({$urandom, $urandom});
    do_step($urandom, 5, 1'b1, 1'b1);

    for (int i = 0; i < 500 && (exp_q.size() != 0 || o_res_valid); i++) @(negedge i_clk);
    check("drain_results", exp_q.size(), 0);
    repeat (5) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
